// File: rtl/register_shadow_bank.sv
// Purpose     : shadow/active register bank; writes land in shadow, dirty registers commit atomically on frame_start.
// Latency     : shadow and dirty_mask update 1 edge after a write; active_regs and commit_pulse change 2 edges after frame_start is raised.
// Backpressure: none; one (register_index, register_value) entry is accepted every clock, index 0 is the idle code.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   register_index      register selector 1..NUM_REGS; 0 or out of range means no write
//   register_value      value written to the selected shadow register
//   frame_start         one-cycle pulse at the start of vertical blanking
//   active_regs         active copy, register k at [k*VALUE_WIDTH-1 -: VALUE_WIDTH]
//   dirty_mask          bit k-1 set while shadow register k differs from active
//   pending             registered OR of dirty_mask
//   commit_pulse        high in the first cycle new active values are visible
// Optional (REGISTER_SHADOW_BANK_READBACK_EN):
//   readback_index      shadow register to read back
//   readback_value      registered shadow value (0 for index 0 / out of range)
//   readback_dirty      registered dirty bit of readback_index
module register_shadow_bank #(
  parameter int NUM_REGS    = 15,
  parameter int INDEX_WIDTH = 4,
  parameter int VALUE_WIDTH = 23
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [INDEX_WIDTH-1:0]          register_index,
  input  logic [VALUE_WIDTH-1:0]          register_value,
  input  logic                            frame_start,
`ifdef REGISTER_SHADOW_BANK_READBACK_EN
  input  logic [INDEX_WIDTH-1:0]          readback_index,
  output logic [VALUE_WIDTH-1:0]          readback_value,
  output logic                            readback_dirty,
`endif
  output logic [NUM_REGS*VALUE_WIDTH-1:0] active_regs,
  output logic [NUM_REGS-1:0]             dirty_mask,
  output logic                            pending,
  output logic                            commit_pulse
);

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

  state_t                 state_q, state_d;
  logic [VALUE_WIDTH-1:0] shadow_q [NUM_REGS];
  logic [VALUE_WIDTH-1:0] shadow_d [NUM_REGS];
  logic [VALUE_WIDTH-1:0] active_q [NUM_REGS];
  logic [VALUE_WIDTH-1:0] active_d [NUM_REGS];
  logic [NUM_REGS-1:0]    dirty_d;
  logic [NUM_REGS-1:0]    commit_set_q, commit_set_d;

  // Datapath. Dirty is recomputed as "next shadow differs from next active",
  // which covers identical rewrites (no change), writes back to the active
  // value (clears the bit) and writes that collide with a commit (active
  // takes the pre-write shadow, the bit re-sets if the new value differs).
  // Matching k+1 against the index also drops index 0 and out-of-range codes.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      shadow_d[k] = shadow_q[k];
      active_d[k] = active_q[k];
      if (register_index == INDEX_WIDTH'(k + 1))
        shadow_d[k] = register_value;
      if (state_q == COMMIT && commit_set_q[k])
        active_d[k] = shadow_q[k];
      dirty_d[k] = (shadow_d[k] != active_d[k]);
    end
  end

  // Control. The commit set is the registered dirty_mask, i.e. taken before
  // any write presented alongside frame_start.
  always_comb begin
    state_d      = state_q;
    commit_set_d = commit_set_q;
    case (state_q)
      IDLE: begin
        if (|dirty_d) state_d = PENDING;
      end
      PENDING: begin
        if (frame_start) begin
          state_d      = COMMIT;
          commit_set_d = dirty_mask;
        end else if (!(|dirty_d)) begin
          // every dirty register was written back to its active value
          state_d = IDLE;
        end
      end
      COMMIT: begin
        // frame_start is deliberately not looked at here
        state_d      = (|dirty_d) ? PENDING : IDLE;
        commit_set_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      commit_set_q <= '0;
      dirty_mask   <= '0;
      pending      <= 1'b0;
      commit_pulse <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      commit_set_q <= commit_set_d;
      dirty_mask   <= dirty_d;
      pending      <= |dirty_mask;
      commit_pulse <= (state_q == COMMIT);
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
    end
  end

  always_comb begin
    active_regs = '0;
    for (int k = 0; k < NUM_REGS; k++)
      active_regs[k*VALUE_WIDTH +: VALUE_WIDTH] = active_q[k];
  end

`ifdef REGISTER_SHADOW_BANK_READBACK_EN
  logic [VALUE_WIDTH-1:0] rb_value_d;
  logic                   rb_dirty_d;

  always_comb begin
    rb_value_d = '0;
    rb_dirty_d = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (readback_index == INDEX_WIDTH'(k + 1)) begin
        rb_value_d = shadow_q[k];
        rb_dirty_d = dirty_mask[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readback_value <= '0;
      readback_dirty <= 1'b0;
    end else begin
      readback_value <= rb_value_d;
      readback_dirty <= rb_dirty_d;
    end
  end
`endif

endmodule

// File: tb/tb_register_shadow_bank.sv
// Purpose     : self-checking bench for register_shadow_bank (14-register build so index 15 is out of range).
// Latency     : commits are expected on commit_pulse exactly 2 edges after frame_start is raised.
// Backpressure: none; a scoreboard queue holds expected commits, a negedge monitor pops one per commit_pulse.
module tb_register_shadow_bank;
  localparam int NR = 14;
  localparam int IW = 4;
  localparam int VW = 23;
  localparam int W  = NR * VW;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] register_index;
  logic [VW-1:0] register_value;
  logic          frame_start;
  logic [W-1:0]  active_regs;
  logic [NR-1:0] dirty_mask;
  logic          pending;
  logic          commit_pulse;
`ifdef REGISTER_SHADOW_BANK_READBACK_EN
  logic [IW-1:0] readback_index;
  logic [VW-1:0] readback_value;
  logic          readback_dirty;
`endif

  register_shadow_bank #(.NUM_REGS(NR), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) dut (
    .clk            (clk),
    .reset          (reset),
    .register_index (register_index),
    .register_value (register_value),
    .frame_start    (frame_start),
`ifdef REGISTER_SHADOW_BANK_READBACK_EN
    .readback_index (readback_index),
    .readback_value (readback_value),
    .readback_dirty (readback_dirty),
`endif
    .active_regs    (active_regs),
    .dirty_mask     (dirty_mask),
    .pending        (pending),
    .commit_pulse   (commit_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int            cyc;
    logic [W-1:0]  act;
    logic [NR-1:0] dm;
  } exp_t;
  exp_t sbq[$];

  logic [W-1:0] ea;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic [VW-1:0] v);
    register_index = IW'(idx);
    register_value = v;
    tick();
    register_index = '0;
  endtask

  task automatic set_ea(input int k, input logic [VW-1:0] v);
    ea[k*VW-1 -: VW] = v;
  endtask

  // Raise frame_start for one cycle and expect a commit with the given image.
  task automatic frame(input logic [W-1:0] a, input logic [NR-1:0] d);
    sbq.push_back('{cyc + 2, a, d});
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
  endtask

  // Monitor: every commit_pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && commit_pulse) begin
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_commit: commit_pulse=1 at cycle %0d, required 0", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("commit_cycle", W'(cyc), W'(e.cyc));
        chk("commit_active", active_regs, e.act);
        chk("commit_dirty", W'(dirty_mask), W'(e.dm));
      end
    end
  end

  initial begin
    reset          = 1'b1;
    register_index = '0;
    register_value = '0;
    frame_start    = 1'b0;
`ifdef REGISTER_SHADOW_BANK_READBACK_EN
    readback_index = '0;
`endif
    ea = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_active", active_regs, '0);
    chk("rst_dirty", W'(dirty_mask), '0);
    chk("rst_pending", W'(pending), '0);
    chk("rst_commit", W'(commit_pulse), '0);

    // single write then commit
    wr(3, 23'h1ABCDE);
    tick();
    chk("a_dirty", W'(dirty_mask), W'(14'h0004));
    chk("a_pending", W'(pending), W'(1'b1));
    chk("a_active_pre", active_regs, '0);
    set_ea(3, 23'h1ABCDE);
    frame(ea, 14'h0000);
    chk("a_dirty_post", W'(dirty_mask), '0);
    chk("a_pending_post", W'(pending), '0);
    chk("a_active_post", active_regs, ea);

    // muxer re-presenting a held value with idle codes in between
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        register_index = 4'd5;
        register_value = 23'h000011;
      end else begin
        register_index = 4'd0;
      end
      tick();
      if (i == 0) chk("b_dirty_first", W'(dirty_mask), W'(14'h0010));
    end
    register_index = '0;
    tick();
    chk("b_dirty_held", W'(dirty_mask), W'(14'h0010));
    chk("b_pending", W'(pending), W'(1'b1));
    chk("b_active", active_regs, ea);

    // write on the frame_start cycle stays dirty until the next frame
    wr(2, 23'h000022);
    set_ea(2, 23'h000022);
    set_ea(5, 23'h000011);
    sbq.push_back('{cyc + 2, ea, 14'h0040});
    frame_start    = 1'b1;
    register_index = 4'd7;
    register_value = 23'h000055;
    tick();
    frame_start    = 1'b0;
    register_index = '0;
    tick();
    tick();
    chk("c_dirty", W'(dirty_mask), W'(14'h0040));
    chk("c_active", active_regs, ea);
    set_ea(7, 23'h000055);
    frame(ea, 14'h0000);
    chk("c_dirty_post", W'(dirty_mask), '0);

    // write during COMMIT to a committing register; frame_start in COMMIT ignored
    wr(4, 23'h0000AA);
    set_ea(4, 23'h0000AA);
    sbq.push_back('{cyc + 2, ea, 14'h0008});
    frame_start = 1'b1;
    tick();
    register_index = 4'd4;
    register_value = 23'h0000BB;
    tick();
    frame_start    = 1'b0;
    register_index = '0;
    repeat (3) tick();
    chk("d_dirty", W'(dirty_mask), W'(14'h0008));
    chk("d_active", active_regs, ea);
    set_ea(4, 23'h0000BB);
    frame(ea, 14'h0000);

    // write-back to the active value clears dirty; idle and out-of-range codes
    wr(3, 23'h000001);
    chk("e_dirty_set", W'(dirty_mask), W'(14'h0004));
    wr(3, 23'h1ABCDE);
    chk("e_dirty_clr", W'(dirty_mask), '0);
    wr(0, 23'h7FFFFF);
    wr(15, 23'h7FFFFF);
    tick();
    chk("e_dirty_oor", W'(dirty_mask), '0);
    chk("e_pending_oor", W'(pending), '0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (3) tick();
    chk("e_active", active_regs, ea);

`ifdef REGISTER_SHADOW_BANK_READBACK_EN
    readback_index = 4'd9;
    wr(9, 23'h012345);
    tick();
    chk("rb_value", W'(readback_value), W'(23'h012345));
    chk("rb_dirty", W'(readback_dirty), W'(1'b1));
    readback_index = 4'd15;
    tick();
    chk("rb_value_oor", W'(readback_value), '0);
    chk("rb_dirty_oor", W'(readback_dirty), '0);
    readback_index = 4'd9;
    set_ea(9, 23'h012345);
    frame(ea, 14'h0000);
    chk("rb_dirty_post", W'(readback_dirty), '0);
    chk("rb_value_post", W'(readback_value), W'(23'h012345));
`endif

    // reset in the middle of a commit leaves no partial copy
    wr(6, 23'h000123);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("r1_active", active_regs, '0);
    chk("r1_dirty", W'(dirty_mask), '0);
    chk("r1_commit", W'(commit_pulse), '0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("r1_active_after", active_regs, '0);
    chk("r1_dirty_after", W'(dirty_mask), '0);

    // asynchronous reset between edges with dirty state present
    wr(6, 23'h000456);
    tick();
    chk("r2_pending_pre", W'(pending), W'(1'b1));
    #2 reset = 1'b1;
    #1;
    chk("r2_dirty", W'(dirty_mask), '0);
    chk("r2_pending", W'(pending), '0);
    chk("r2_active", active_regs, '0);
    tick();
    reset = 1'b0;
    tick();

    chk("sb_drained", W'(sbq.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/register_shadow_bank.md
Name: register_shadow_bank

Overview:
- Sits directly downstream of the two-source register muxer and consumes its (register_index, register_value) stream, one entry per clock.
- Holds a shadow copy and an active copy of the terminal configuration registers.
- Writes land in the shadow copy. Changed registers are transferred to the active copy atomically on a frame boundary, so video timing never sees a half-applied configuration.
- Index 0 is the idle/no-op code.

Parameters:
- NUM_REGS, 15, number of registers, addressed by indices 1..NUM_REGS.
- INDEX_WIDTH, 4, width of register_index.
- VALUE_WIDTH, 23, width of each register.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- register_index  input  INDEX_WIDTH  register selector from the muxer; 0 means no write.
- register_value  input  VALUE_WIDTH  value for the selected register.
- frame_start  input  1  one-cycle pulse at the start of vertical blanking.
- active_regs  output  NUM_REGS*VALUE_WIDTH  active registers, flattened; register k occupies bits [k*VALUE_WIDTH-1 -: VALUE_WIDTH].
- dirty_mask  output  NUM_REGS  bit k-1 set means shadow register k differs from active and is waiting for commit.
- pending  output  1  OR-reduction of dirty_mask, registered.
- commit_pulse  output  1  one-cycle pulse in the cycle active_regs changes.

Behaviour:
- Reset (asynchronous, active-high): all shadow and active registers clear to 0; dirty_mask, pending and commit_pulse clear to 0; FSM goes to IDLE. Reset asserted mid-commit aborts the commit; no partial copy survives.
- Write acceptance:
  - A write is accepted when 1 <= register_index <= NUM_REGS.
  - Index 0 is ignored. Index > NUM_REGS is ignored silently.
  - The shadow register is updated on the clock edge following presentation.
- Change detection:
  - The dirty bit sets only if register_value differs from the current shadow value.
  - Rewriting an identical value has no effect. This is required because the muxer re-presents held values every other cycle.
  - Writing a value equal to the active value clears that dirty bit, since shadow again matches active.
- pending: follows dirty_mask with one cycle latency.
- FSM:
  - IDLE: no dirty bits. A write that sets a dirty bit moves to PENDING. frame_start in IDLE does nothing; no commit_pulse.
  - PENDING: on frame_start, go to COMMIT. A latched copy of dirty_mask is the commit set.
  - COMMIT (1 cycle):
    - active[k] <= shadow[k] for each k in the commit set.
    - Commit-set bits are cleared in dirty_mask.
    - commit_pulse = 1 in the cycle the new active values are visible, i.e. two edges after the frame_start edge.
    - Next state is PENDING if any dirty bit remains, otherwise IDLE.
- Simultaneous events:
  - Write on the frame_start cycle: the commit set is taken before the write. The written register's new value stays in shadow, dirty, until the next frame.
  - Write during COMMIT to a register in the commit set: shadow takes the new value. Active takes the pre-write shadow value. The dirty bit is re-set if the new shadow differs from the committed value.
  - frame_start while in COMMIT is ignored.
- Registers not in the commit set never change in active_regs.

Optional Feature:
- Macro: REGISTER_SHADOW_BANK_READBACK_EN.
- When defined, the block adds:
  - input readback_index (INDEX_WIDTH);
  - output readback_value (VALUE_WIDTH), registered, 1-cycle latency, returning the shadow value of readback_index, or 0 for index 0 or index > NUM_REGS;
  - output readback_dirty (1), the corresponding dirty bit.
- When undefined: those ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset asserted asynchronously between edges -> active_regs, dirty_mask, pending, commit_pulse all 0 immediately, without waiting for a clock edge.
- Write idx 3 = 23'h1ABCDE, then frame_start -> dirty_mask=15'h0004 and pending=1 before the commit; commit_pulse exactly two edges after the frame_start edge; register 3 = 23'h1ABCDE; all other registers 0; dirty_mask=0; FSM back in IDLE.
- Alternate idx 5 = 23'h000011 with idx 0 for 20 cycles, no frame_start -> dirty bit 4 set once and stays set; active register 5 still 0; no commit_pulse.
- Idx 7 = 23'h000055 presented in the same cycle as frame_start, with idx 2 already dirty -> register 2 commits; register 7 remains 0 in active with dirty bit 6 set; next frame_start commits 23'h000055.
- Idx 0 and idx 15 (NUM_REGS=14 build) written with 23'h7FFFFF -> no dirty bits, no state change; frame_start produces no commit_pulse.
- With REGISTER_SHADOW_BANK_READBACK_EN: write idx 9 = 23'h012345, readback_index=9 -> readback_value=23'h012345 and readback_dirty=1 one cycle later; after commit, readback_dirty=0.
